// File: rtl/fight_round_ctrl.sv
// fight_round_ctrl: match sequencer for the two-player fighting datapath.
// Collects one action per player per turn, issues them as a single step strobe,
// samples the returned health, scores rounds and declares the match winner.
// Optional feature: define ROUND_TIMER_EN to end a round after ROUND_TICKS steps
// (higher health wins, equal health is a draw round, winner 2'b11 on round overflow).
module fight_round_ctrl #(
  parameter int ROUNDS_TO_WIN = 2,
  parameter int ACT_TIMEOUT   = 15,
  parameter int SETTLE_CYC    = 2,
  parameter int ROUND_TICKS   = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       act1_valid,
  input  logic [2:0] act1,
  output logic       act1_ready,
  input  logic       act2_valid,
  input  logic [2:0] act2,
  output logic       act2_ready,
  input  logic [1:0] health1,
  input  logic [1:0] health2,
  output logic       step,
  output logic [2:0] action1_out,
  output logic [2:0] action2_out,
  output logic       round_rst,
  output logic [3:0] round_num,
  output logic [2:0] wins1,
  output logic [2:0] wins2,
  output logic [1:0] winner,
  output logic       match_done
);

  typedef enum logic [2:0] {
    S_IDLE, S_ROUND_INIT, S_COLLECT, S_ISSUE, S_SETTLE, S_MATCH_END
  } state_e;

  localparam logic [2:0] ACT_AWAIT = 3'b010;
  localparam int TMO_W = (ACT_TIMEOUT > 1) ? $clog2(ACT_TIMEOUT) : 1;
  localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACT_TIMEOUT - 1);
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYC - 1);
  localparam logic [2:0]       WIN_LAST = 3'(ROUNDS_TO_WIN - 1);

  state_e           state_q, state_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [SET_W-1:0] settle_q, settle_d;
  logic             got1_q, got1_d, got2_q, got2_d;
  logic [2:0]       action1_q, action1_d, action2_q, action2_d;
  logic [3:0]       round_q, round_d;
  logic [2:0]       wins1_q, wins1_d, wins2_q, wins2_d;
  logic [1:0]       winner_q, winner_d;

  logic in_collect, cap1, cap2, tmo_fire, turn_done, sample, ko1, ko2;
  logic p1_round, p2_round, draw_round, replay, p1_match, p2_match;
  logic next_round, round_ovf, restart;

`ifdef ROUND_TIMER_EN
  localparam int STEP_W = $clog2(ROUND_TICKS + 1);
  logic [STEP_W-1:0] steps_q, steps_d;
`else
  logic unused_round_ticks;
  assign unused_round_ticks = (ROUND_TICKS > 0);
`endif

  // Decode captures, turn completion and the end-of-settle round verdict
  always_comb begin
    // NOTE: every signal gets a default before any conditional override so no latch is inferred.
    in_collect = (state_q == S_COLLECT);
    cap1       = in_collect && act1_valid && !got1_q;
    cap2       = in_collect && act2_valid && !got2_q;
    tmo_fire   = in_collect && (tmo_q == TMO_LAST);
    turn_done  = in_collect && (((got1_q || cap1) && (got2_q || cap2)) || tmo_fire);
    sample     = (state_q == S_SETTLE) && (settle_q == SET_LAST);
    ko1        = (health1 == 2'd0);
    ko2        = (health2 == 2'd0);
    p1_round   = sample && ko2 && !ko1;
    p2_round   = sample && ko1 && !ko2;
    replay     = sample && ko1 && ko2;
    draw_round = 1'b0;
`ifdef ROUND_TIMER_EN
    if (sample && !ko1 && !ko2 && (steps_q == STEP_W'(ROUND_TICKS))) begin
      if (health1 > health2)      p1_round   = 1'b1;
      else if (health2 > health1) p2_round   = 1'b1;
      else                        draw_round = 1'b1;
    end
`endif
    p1_match   = p1_round && (wins1_q == WIN_LAST);
    p2_match   = p2_round && (wins2_q == WIN_LAST);
    next_round = (p1_round && !p1_match) || (p2_round && !p2_match) || draw_round;
`ifdef ROUND_TIMER_EN
    round_ovf  = next_round && (round_q == 4'd15);
`else
    round_ovf  = 1'b0;
`endif
    restart    = start && ((state_q == S_IDLE) || (state_q == S_MATCH_END));
  end

  // Next-state logic of the match sequencer
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_MATCH_END: if (start) state_d = S_ROUND_INIT;
      S_ROUND_INIT:        state_d = S_COLLECT;
      S_COLLECT:           if (turn_done) state_d = S_ISSUE;
      S_ISSUE:             state_d = S_SETTLE;
      S_SETTLE: begin
        if (sample) begin
          if (p1_match || p2_match || round_ovf) state_d = S_MATCH_END;
          else if (next_round || replay)         state_d = S_ROUND_INIT;
          else                                   state_d = S_COLLECT;
        end
      end
      default:             state_d = S_IDLE;
    endcase
  end

  // Datapath: phase counters, action capture, scoring and round bookkeeping
  always_comb begin
    tmo_d     = in_collect ? tmo_q + 1'b1 : '0;
    settle_d  = (state_q == S_SETTLE) ? settle_q + 1'b1 : '0;
    got1_d    = in_collect && (got1_q || cap1);
    got2_d    = in_collect && (got2_q || cap2);
    // A capture in the timeout cycle takes priority over the forced await.
    action1_d = action1_q;
    if (cap1)                     action1_d = act1;
    else if (tmo_fire && !got1_q) action1_d = ACT_AWAIT;
    action2_d = action2_q;
    if (cap2)                     action2_d = act2;
    else if (tmo_fire && !got2_q) action2_d = ACT_AWAIT;
    round_d   = round_q;
    wins1_d   = wins1_q;
    wins2_d   = wins2_q;
    winner_d  = winner_q;
    if (restart) begin
      round_d  = 4'd1;
      wins1_d  = '0;
      wins2_d  = '0;
      winner_d = 2'b00;
    end
    if (p1_round) wins1_d = wins1_q + 3'd1;
    if (p2_round) wins2_d = wins2_q + 3'd1;
    if (p1_match)                                round_d = round_q;
    if (p1_match)                                winner_d = 2'b01;
    else if (p2_match)                           winner_d = 2'b10;
    else if (round_ovf)                          winner_d = 2'b11;
    else if (next_round && (round_q != 4'd15))   round_d  = round_q + 4'd1;
`ifdef ROUND_TIMER_EN
    steps_d = steps_q;
    if (state_q == S_ROUND_INIT) steps_d = '0;
    else if (state_q == S_ISSUE) steps_d = steps_q + 1'b1;
`endif
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q   <= S_IDLE;
      tmo_q     <= '0;
      settle_q  <= '0;
      got1_q    <= 1'b0;
      got2_q    <= 1'b0;
      action1_q <= ACT_AWAIT;
      action2_q <= ACT_AWAIT;
      round_q   <= '0;
      wins1_q   <= '0;
      wins2_q   <= '0;
      winner_q  <= 2'b00;
`ifdef ROUND_TIMER_EN
      steps_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      tmo_q     <= tmo_d;
      settle_q  <= settle_d;
      got1_q    <= got1_d;
      got2_q    <= got2_d;
      action1_q <= action1_d;
      action2_q <= action2_d;
      round_q   <= round_d;
      wins1_q   <= wins1_d;
      wins2_q   <= wins2_d;
      winner_q  <= winner_d;
`ifdef ROUND_TIMER_EN
      steps_q   <= steps_d;
`endif
    end
  end

  // Outputs: strobes and readies from the current state, the rest from registers
  always_comb begin
    act1_ready  = (state_q == S_COLLECT) && !got1_q;
    act2_ready  = (state_q == S_COLLECT) && !got2_q;
    step        = (state_q == S_ISSUE);
    round_rst   = (state_q == S_ROUND_INIT);
    match_done  = (state_q == S_MATCH_END);
    action1_out = action1_q;
    action2_out = action2_q;
    round_num   = round_q;
    wins1       = wins1_q;
    wins2       = wins2_q;
    winner      = winner_q;
  end

endmodule

// File: tb/tb_fight_round_ctrl.sv
// Bench for fight_round_ctrl: a turn-level behavioural model compared on every
// falling edge, plus directed scenarios with hand-computed literal expectations.
module tb_fight_round_ctrl;

  localparam int ROUNDS_TO_WIN = 2;
  localparam int ACT_TIMEOUT   = 15;
  localparam int SETTLE_CYC    = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       act1_valid = 1'b0, act2_valid = 1'b0;
  logic [2:0] act1 = 3'd0, act2 = 3'd0;
  logic [1:0] health1 = 2'd3, health2 = 2'd3;
  logic       act1_ready, act2_ready, step, round_rst, match_done;
  logic [2:0] action1_out, action2_out, wins1, wins2;
  logic [3:0] round_num;
  logic [1:0] winner;

  int n_total = 0;
  int n_pass  = 0;
  bit cmp_en  = 1'b0;

  fight_round_ctrl #(
    .ROUNDS_TO_WIN(ROUNDS_TO_WIN), .ACT_TIMEOUT(ACT_TIMEOUT),
    .SETTLE_CYC(SETTLE_CYC), .ROUND_TICKS(64)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .act1_valid(act1_valid), .act1(act1), .act1_ready(act1_ready),
    .act2_valid(act2_valid), .act2(act2), .act2_ready(act2_ready),
    .health1(health1), .health2(health2),
    .step(step), .action1_out(action1_out), .action2_out(action2_out),
    .round_rst(round_rst), .round_num(round_num),
    .wins1(wins1), .wins2(wins2), .winner(winner), .match_done(match_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
  endtask

  // ---------------- behavioural model: turn / round / match rules ----------------
  typedef enum {M_IDLE, M_INIT, M_COLLECT, M_ISSUE, M_SETTLE, M_END} mode_e;
  mode_e      m_mode = M_IDLE;
  bit         m_have1, m_have2;
  int         m_age, m_wait;
  logic [2:0] m_a1 = 3'b010, m_a2 = 3'b010;
  int         m_round = 0, m_wins1 = 0, m_wins2 = 0;
  logic [1:0] m_winner = 2'b00;

  function automatic void m_open_turn();
    m_mode = M_COLLECT; m_have1 = 1'b0; m_have2 = 1'b0; m_age = 0;
  endfunction

  function automatic void m_score(input int p);
    int w;
    if (p == 1) begin m_wins1++; w = m_wins1; end
    else        begin m_wins2++; w = m_wins2; end
    if (w == ROUNDS_TO_WIN) begin
      m_winner = 2'(p);
      m_mode   = M_END;
    end else begin
      m_round = (m_round < 15) ? m_round + 1 : 15;
      m_mode  = M_INIT;
    end
  endfunction

  function automatic void m_tick();
    if (rst) begin
      m_mode = M_IDLE; m_a1 = 3'b010; m_a2 = 3'b010;
      m_round = 0; m_wins1 = 0; m_wins2 = 0; m_winner = 2'b00;
      return;
    end
    case (m_mode)
      M_IDLE, M_END: if (start) begin
        m_mode = M_INIT; m_round = 1; m_wins1 = 0; m_wins2 = 0; m_winner = 2'b00;
      end
      M_INIT: m_open_turn();
      M_COLLECT: begin
        if (!m_have1 && act1_valid) begin m_have1 = 1'b1; m_a1 = act1; end
        if (!m_have2 && act2_valid) begin m_have2 = 1'b1; m_a2 = act2; end
        m_age++;
        if (m_have1 && m_have2) m_mode = M_ISSUE;
        else if (m_age == ACT_TIMEOUT) begin
          if (!m_have1) m_a1 = 3'b010;
          if (!m_have2) m_a2 = 3'b010;
          m_mode = M_ISSUE;
        end
      end
      M_ISSUE: begin m_mode = M_SETTLE; m_wait = 0; end
      M_SETTLE: begin
        m_wait++;
        if (m_wait == SETTLE_CYC) begin
          if (health1 == 0 && health2 == 0) m_mode = M_INIT;
          else if (health2 == 0)            m_score(1);
          else if (health1 == 0)            m_score(2);
          else                              m_open_turn();
        end
      end
      default: m_mode = M_IDLE;
    endcase
  endfunction

  initial forever begin
    @(posedge clk);
    m_tick();
  end

  // Compare every DUT output against the model on each falling edge
  initial forever begin
    @(negedge clk);
    if (cmp_en) begin
      check("m_step",       8'(step),        8'(m_mode == M_ISSUE));
      check("m_round_rst",  8'(round_rst),   8'(m_mode == M_INIT));
      check("m_ready1",     8'(act1_ready),  8'(m_mode == M_COLLECT && !m_have1));
      check("m_ready2",     8'(act2_ready),  8'(m_mode == M_COLLECT && !m_have2));
      check("m_action1",    8'(action1_out), 8'(m_a1));
      check("m_action2",    8'(action2_out), 8'(m_a2));
      check("m_round_num",  8'(round_num),   8'(m_round));
      check("m_wins1",      8'(wins1),       8'(m_wins1));
      check("m_wins2",      8'(wins2),       8'(m_wins2));
      check("m_winner",     8'(winner),      8'(m_winner));
      check("m_match_done", 8'(match_done),  8'(m_mode == M_END));
    end
  end

  // ---------------- directed stimulus ----------------
  // which: 0 act1_ready, 1 step, 2 round_rst, 3 match_done
  task automatic wait_for(input int which, input int budget, output int n);
    bit hit;
    n = 0; hit = 1'b0;
    while (!hit && n < budget) begin
      @(negedge clk);
      n++;
      case (which)
        0:       hit = act1_ready;
        1:       hit = step;
        2:       hit = round_rst;
        default: hit = match_done;
      endcase
    end
    check("wait_event", 8'(hit), 8'd1);
  endtask

  task automatic do_turn(input logic [2:0] a1, input logic [2:0] a2,
                         input logic [1:0] h1, input logic [1:0] h2);
    int n;
    wait_for(0, 40, n);
    act1_valid = 1'b1; act1 = a1;
    act2_valid = 1'b1; act2 = a2;
    health1 = h1; health2 = h2;
    @(negedge clk);
    act1_valid = 1'b0; act2_valid = 1'b0;
  endtask

  initial begin
    int n;
    repeat (2) @(negedge clk);
    cmp_en = 1'b1;
    check("rst_round_num", 8'(round_num),   8'd0);
    check("rst_action1",   8'(action1_out), 8'd2);
    check("rst_action2",   8'(action2_out), 8'd2);
    check("rst_step",      8'(step),        8'd0);
    check("rst_winner",    8'(winner),      8'd0);
    rst = 1'b0;

    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("start_round_rst", 8'(round_rst), 8'd1);
    check("start_round_num", 8'(round_num), 8'd1);

    // Both actions offered together: one step, readies drop, actions latched.
    do_turn(3'b000, 3'b010, 2'd3, 2'd3);
    check("pair_step",    8'(step),        8'd1);
    check("pair_ready1",  8'(act1_ready),  8'd0);
    check("pair_ready2",  8'(act2_ready),  8'd0);
    check("pair_action1", 8'(action1_out), 8'd0);
    check("pair_action2", 8'(action2_out), 8'd2);
    @(negedge clk);
    check("pair_single_step", 8'(step), 8'd0);

    // Only player1 acts (valid held): player2 forced to await after timeout.
    wait_for(0, 40, n);
    act1_valid = 1'b1; act1 = 3'b101;
    wait_for(1, 30, n);
    act1_valid = 1'b0;
    check("tmo_latency", 8'(n),           8'd15);
    check("tmo_action1", 8'(action1_out), 8'd5);
    check("tmo_action2", 8'(action2_out), 8'd2);

    // Player2 KO twice: round to player1, then match to player1.
    do_turn(3'b001, 3'b011, 2'd3, 2'd0);
    wait_for(2, 20, n);
    health2 = 2'd3;
    check("ko_wins1",     8'(wins1),     8'd1);
    check("ko_wins2",     8'(wins2),     8'd0);
    check("ko_round_num", 8'(round_num), 8'd2);
    do_turn(3'b001, 3'b011, 2'd3, 2'd0);
    wait_for(3, 20, n);
    health2 = 2'd3;
    check("match_winner", 8'(winner), 8'd1);
    check("match_wins1",  8'(wins1),  8'd2);
    repeat (3) @(negedge clk);
    check("match_held", 8'(match_done), 8'd1);

    // Restart from MATCH_END, player2 takes a round, then a double KO replay.
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("restart_round_num", 8'(round_num), 8'd1);
    check("restart_winner",    8'(winner),    8'd0);
    check("restart_wins1",     8'(wins1),     8'd0);
    do_turn(3'b000, 3'b000, 2'd0, 2'd3);
    wait_for(2, 20, n);
    health1 = 2'd3;
    check("p2_wins2",     8'(wins2),     8'd1);
    check("p2_round_num", 8'(round_num), 8'd2);
    wait_for(0, 40, n);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    do_turn(3'b110, 3'b111, 2'd0, 2'd0);
    wait_for(2, 20, n);
    health1 = 2'd3; health2 = 2'd3;
    check("dko_wins1",     8'(wins1),     8'd0);
    check("dko_wins2",     8'(wins2),     8'd1);
    check("dko_round_num", 8'(round_num), 8'd2);

    // Reset during SETTLE wins over everything.
    do_turn(3'b010, 3'b100, 2'd3, 2'd3);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_step",      8'(step),        8'd0);
    check("mid_rst_round_rst", 8'(round_rst),   8'd0);
    check("mid_rst_wins2",     8'(wins2),       8'd0);
    check("mid_rst_round_num", 8'(round_num),   8'd0);
    check("mid_rst_action1",   8'(action1_out), 8'd2);
    check("mid_rst_action2",   8'(action2_out), 8'd2);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
